// File: rtl/alu_issue_ctrl.sv
// Two-state issue controller for an 8-bit ALU. It accepts an instruction in IDLE,
// then commits the ALU result, PC update and retire accounting at the end of EXEC.
module alu_issue_ctrl #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [15:0]      ins_data,
    output logic [PC_W-1:0]  pc,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_sel,
    input  logic [7:0]       alu_f,
    input  logic             alu_ovf,
    input  logic             alu_take_branch,
    output logic             ovf_flag,
    input  logic             ovf_clr,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    input  logic [1:0]       dbg_sel,
    output logic [7:0]       dbg_data
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [7:0]       rf_q [4];
    logic [7:0]       rf_d [4];
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [1:0]       rd_q, rd_d;
    logic [6:0]       imm_q, imm_d;
    logic             ovf_q, ovf_d;
    logic             retire_q, retire_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             is_branch;
    logic [PC_W-1:0]  imm_ext;

    assign ins_ready = (state_q == IDLE) && !rst;
    assign accept    = ins_valid && ins_ready;
    assign is_branch = alu_sel_q[2] && alu_sel_q[1];
    assign imm_ext   = PC_W'($signed(imm_q));

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rf_d      = rf_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        ovf_d     = ovf_q && !ovf_clr;
        retire_d  = 1'b0;
        cnt_d     = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_sel_d = ins_data[15:13];
                    rd_d      = ins_data[12:11];
                    alu_a_d   = rf_q[ins_data[10:9]];
                    alu_b_d   = rf_q[ins_data[8:7]];
                    imm_d     = ins_data[6:0];
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                state_d  = IDLE;
                retire_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (is_branch) begin
                    pc_d = alu_take_branch ? (pc_q + imm_ext) : (pc_q + PC_W'(1));
                end else begin
                    rf_d[rd_q] = alu_f;
                    pc_d       = pc_q + PC_W'(1);
                    // A fresh overflow outranks a coincident clear
                    if ((alu_sel_q == 3'b000) && alu_ovf) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            ovf_q     <= 1'b0;
            retire_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rf_q      <= rf_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            ovf_q     <= ovf_d;
            retire_q  <= retire_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pc         = pc_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign ovf_flag   = ovf_q;
    assign retire     = retire_q;
    assign retire_cnt = cnt_q;
    assign dbg_data   = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl. The bench supplies the ALU and keeps an
// architectural model of the register file, PC, overflow flag and retire count.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins_data;
    logic [7:0]  pc;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_f;
    logic        alu_ovf;
    logic        alu_take_branch;
    logic        ovf_flag;
    logic        ovf_clr;
    logic        retire;
    logic [15:0] retire_cnt;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] rf;
        logic        ovf;
        logic [15:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] m_rf [4];
    int         m_pc;
    bit         m_ovf;
    int         m_cnt;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_data(ins_data), .pc(pc), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_f(alu_f), .alu_ovf(alu_ovf),
        .alu_take_branch(alu_take_branch), .ovf_flag(ovf_flag), .ovf_clr(ovf_clr),
        .retire(retire), .retire_cnt(retire_cnt), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ALU behaviour: returns {take_branch, ovf, f}, computed on integer values
    function automatic logic [9:0] aluFn(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        int ia = a;
        int ib = b;
        int sa = (a > 127) ? ia - 256 : ia;
        int sbv = (b > 127) ? ib - 256 : ib;
        int sum;
        logic [7:0] f = 8'd0;
        logic ov = 1'b0;
        logic tk = 1'b0;
        case (sel)
            3'd0: begin
                sum = sa + sbv;
                f = 8'((sum + 256) % 256);
                ov = (sum > 127) || (sum < -128);
            end
            3'd1: f = 8'(255 - ib);
            3'd2: f = a & b;
            3'd3: f = a | b;
            3'd4: f = a ^ b;
            3'd5: f = 8'((ia * 2) % 256);
            3'd6: tk = (ia == ib);
            default: tk = (ia != ib);
        endcase
        return {tk, ov, f};
    endfunction

    assign {alu_take_branch, alu_ovf, alu_f} = aluFn(alu_sel, alu_a, alu_b);

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_pc = 0;
        m_ovf = 1'b0;
        m_cnt = 0;
    endfunction

    // Architectural effect of one instruction, pushed as the expected retire state
    function automatic void refExec(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                    input logic [1:0] rs2, input logic [6:0] imm, input bit clr);
        logic [9:0] r = aluFn(op, m_rf[rs1], m_rf[rs2]);
        int off = imm[6] ? int'(imm) - 128 : int'(imm);
        exp_t e;
        m_ovf = m_ovf && !clr;
        if (op >= 3'd6) begin
            m_pc = r[9] ? (((m_pc + off) % 256) + 256) % 256 : (m_pc + 1) % 256;
        end else begin
            m_rf[rd] = r[7:0];
            m_pc = (m_pc + 1) % 256;
            if (op == 3'd0 && r[8]) m_ovf = 1'b1;
        end
        if (m_cnt < 65535) m_cnt++;
        e.pc = 8'(m_pc);
        e.rf = {m_rf[3], m_rf[2], m_rf[1], m_rf[0]};
        e.ovf = m_ovf;
        e.cnt = 16'(m_cnt);
        sb.push_back(e);
    endfunction

    // Issue one instruction; returns at the negedge where retire should be high
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                 input logic [1:0] rs2, input logic [6:0] imm, input bit clr);
        int w = 0;
        while (!ins_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!ins_ready) begin
            checkOutput("ready_timeout", 0, 1);
            return;
        end
        ins_valid = 1'b1;
        ins_data = {op, rd, rs1, rs2, imm};
        refExec(op, rd, rs1, rs2, imm, clr);
        @(negedge clk);
        ins_valid = 1'b0;
        ovf_clr = clr;
        checkOutput("ready_in_exec", int'(ins_ready), 0);
        @(negedge clk);
        ovf_clr = 1'b0;
        checkOutput("retire_latency", int'(retire), 1);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        ins_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("ready_in_reset", int'(ins_ready), 0);
        end
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("ready_after_reset", int'(ins_ready), 1);
        checkOutput("pc_after_reset", int'(pc), 0);
        checkOutput("cnt_after_reset", int'(retire_cnt), 0);
        @(negedge clk);
    endtask

    task automatic clearOvf();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: checks reset register contents, then every retire against the scoreboard
    initial begin
        bit prev_retire = 1'b0;
        exp_t e;
        logic [7:0] rv;
        dbg_sel = 2'd0;
        for (int i = 0; i < 50 && rst; i++) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            checkOutput("rf_reset", int'(dbg_data), 0);
        end
        forever begin
            @(negedge clk);
            if (retire && prev_retire) checkOutput("retire_width", 2, 1);
            prev_retire = retire;
            if (retire) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_retire", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("pc", int'(pc), int'(e.pc));
                    checkOutput("ovf_flag", int'(ovf_flag), int'(e.ovf));
                    checkOutput("retire_cnt", int'(retire_cnt), int'(e.cnt));
                    for (int i = 0; i < 4; i++) begin
                        dbg_sel = 2'(i);
                        #1;
                        rv = e.rf[i*8 +: 8];
                        checkOutput("rf", int'(dbg_data), int'(rv));
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        ins_valid = 1'b0;
        ins_data = 16'h0000;
        ovf_clr = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", int'(ins_ready), 1);
        checkOutput("pc_after_reset", int'(pc), 0);
        checkOutput("cnt_after_reset", int'(retire_cnt), 0);
        @(negedge clk);

        // NOT then ADD of 0xFF + 0xFF: no signed overflow
        applyStimulus(3'd1, 2'd1, 2'd0, 2'd0, 7'd0, 1'b0);
        checkOutput("pc_after_not", int'(pc), 1);
        applyStimulus(3'd0, 2'd2, 2'd1, 2'd1, 7'd0, 1'b0);
        checkOutput("ovf_no_set", int'(ovf_flag), 0);

        // Walk rf1 down to 0x80, form 0x7F, then overflow with a coincident clear
        for (int i = 0; i < 7; i++) applyStimulus(3'd5, 2'd1, 2'd1, 2'd0, 7'd0, 1'b0);
        applyStimulus(3'd1, 2'd3, 2'd0, 2'd1, 7'd0, 1'b0);
        applyStimulus(3'd0, 2'd3, 2'd3, 2'd3, 7'd0, 1'b1);
        checkOutput("ovf_set_wins", int'(ovf_flag), 1);
        clearOvf();
        checkOutput("ovf_cleared", int'(ovf_flag), 0);

        // Branches: taken forward, not taken, taken backward across zero
        doReset();
        repeat (3) applyStimulus(3'd2, 2'd0, 2'd0, 2'd0, 7'd0, 1'b0);
        applyStimulus(3'd6, 2'd1, 2'd0, 2'd0, 7'd5, 1'b0);
        checkOutput("pc_beq_fwd", int'(pc), 8);
        applyStimulus(3'd7, 2'd1, 2'd0, 2'd0, 7'd5, 1'b0);
        checkOutput("pc_bne_not", int'(pc), 9);
        doReset();
        repeat (2) applyStimulus(3'd2, 2'd0, 2'd0, 2'd0, 7'd0, 1'b0);
        applyStimulus(3'd6, 2'd2, 2'd0, 2'd0, 7'h7C, 1'b0);
        checkOutput("pc_beq_back", int'(pc), 8'hFE);

        // Valid held for six cycles: three accepts, ready alternating
        doReset();
        for (int k = 0; k < 3; k++) refExec(3'd1, 2'd3, 2'd0, 2'd3, 7'd0, 1'b0);
        ins_valid = 1'b1;
        ins_data = {3'd1, 2'd3, 2'd0, 2'd3, 7'd0};
        for (int k = 0; k < 6; k++) begin
            checkOutput("ready_pattern", int'(ins_ready), (k % 2 == 0) ? 1 : 0);
            @(negedge clk);
        end
        ins_valid = 1'b0;
        checkOutput("cnt_after_hold", int'(retire_cnt), 3);

        // Randomised traffic with occasional clears during EXEC
        for (int n = 0; n < 60; n++) begin
            applyStimulus(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)),
                          ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset during EXEC abandons the instruction
        doReset();
        applyStimulus(3'd1, 2'd1, 2'd0, 2'd0, 7'd0, 1'b0);
        ins_valid = 1'b1;
        ins_data = {3'd0, 2'd2, 2'd1, 2'd1, 7'd0};
        @(negedge clk);
        ins_valid = 1'b0;
        rst = 1'b1;
        checkOutput("ready_rst_exec", int'(ins_ready), 0);
        @(negedge clk);
        checkOutput("no_retire_abort", int'(retire), 0);
        checkOutput("ready_rst_hold", int'(ins_ready), 0);
        rst = 1'b0;
        modelReset();
        #1;
        checkOutput("ready_after_abort", int'(ins_ready), 1);
        checkOutput("pc_after_abort", int'(pc), 0);
        @(negedge clk);
        applyStimulus(3'd7, 2'd0, 2'd2, 2'd2, 7'd3, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Instruction-issue controller that drives the 8-bit signed ALU (3-bit op select; outputs f, ovf, take_branch) from the controller's side. It accepts 16-bit instruction words over a valid/ready handshake. It reads operands from an internal 4x8 register file and presents them and the op select to the ALU. It then writes back the result and advances an 8-bit program counter, taking relative branches when the ALU signals take_branch.

Parameters:
PC_W, 8, program counter width; wraps modulo 2^PC_W.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
ins_valid  in  1  instruction word valid
ins_ready  out  1  controller can accept an instruction
ins_data  in  16  [15:13] op, [12:11] rd, [10:9] rs1, [8:7] rs2, [6:0] imm7 (signed branch offset)
pc  out  PC_W  address of the next instruction expected
alu_a  out  8  operand A = rf[rs1]
alu_b  out  8  operand B = rf[rs2]
alu_sel  out  3  op field, forwarded unchanged to the ALU
alu_f  in  8  ALU result (combinational from alu_a/alu_b/alu_sel)
alu_ovf  in  1  ALU signed-add overflow
alu_take_branch  in  1  ALU branch condition
ovf_flag  out  1  sticky overflow flag
ovf_clr  in  1  clears ovf_flag
retire  out  1  one-cycle pulse per completed instruction
retire_cnt  out  CNT_W  retired instruction count, saturating
dbg_sel  in  2  register file debug read index
dbg_data  out  8  rf[dbg_sel], combinational

Behaviour:
- Reset values: pc=0, rf[0..3]=0, alu_a=alu_b=0, alu_sel=0, ovf_flag=0, retire=0, retire_cnt=0, state=IDLE.
- ins_ready is forced 0 while rst=1.
- FSM has two states, IDLE and EXEC.
- ins_ready = (state==IDLE) & ~rst.
- IDLE: on ins_valid&ins_ready, capture op/rd/imm7. Register alu_a<=rf[rs1], alu_b<=rf[rs2], alu_sel<=op. Go to EXEC.
- EXEC lasts exactly one cycle. At its closing edge, sample alu_f/alu_ovf/alu_take_branch and go to IDLE.
- Throughput is one instruction per 2 cycles. An instruction accepted at edge N retires at edge N+1, and ins_ready is high again in the cycle after N+1.
- ins_valid is ignored in EXEC: no accept and no double capture while valid is held.
- Op 000-101: rf[rd]<=alu_f and pc<=pc+1.
- Op 000 only: if alu_ovf then ovf_flag<=1.
- Op 110/111 (branch): no register write. If alu_take_branch then pc<=pc+sext(imm7), else pc<=pc+1. Arithmetic is modulo 2^PC_W.
- The rd write uses the value sampled in EXEC. Operands were latched at accept, so rd==rs1/rs2 is well defined.
- retire pulses high in the cycle following the EXEC closing edge.
- retire_cnt increments at the same edge and holds at all-ones.
- ovf_flag: ovf_clr clears it. If an overflow set and ovf_clr occur in the same cycle, the set wins.
- alu_a/alu_b/alu_sel hold their values in IDLE until the next accept.
- Reset asserted in EXEC abandons the instruction: no rf write, no pc change beyond reset, no retire pulse.

Test Plan:
- Reset then release -> pc=0, ins_ready=1, dbg_data=0 for all four indices, retire_cnt=0.
- NOT (op 001) rd=1, rs2=0 -> rf1=0xFF, pc=1, retire pulse exactly one cycle. Then ADD rd=2, rs1=rs2=1 -> rf2=0xFE, ovf_flag stays 0.
- Build rf1=0x80 by seven SHL (op 101) of rf1 starting at 0xFF. Then NOT rd=3, rs2=1 -> rf3=0x7F. Then ADD rd=3, rs1=rs2=3 -> rf3=0xFE, ovf_flag=1. Assert ovf_clr in the same cycle as that overflow -> flag still 1. ovf_clr alone later -> 0.
- At pc=3, BEQ (op 110) rs1=rs2=0, imm7=+5 -> pc=8. BNE (op 111) rs1=rs2=0 -> pc=9. At pc=2, BEQ taken, imm7=-4 -> pc=0xFE, with no register write in any case.
- Hold ins_valid high continuously for 6 cycles -> exactly 3 accepts, ins_ready pattern 1,0,1,0,1,0, retire_cnt=3.
- Accept ADD rd=2, then assert rst during EXEC -> rf2=0, pc=0, no retire pulse, ins_ready=0 during reset and 1 after.
